// File: rtl/amba_axi_read_burst.sv
// AXI3 read-burst master: accepts a start address/length, issues one INCR AR burst and buffers
// the returned beats in a show-ahead FIFO. Define AMBA_AXI_READ_RESP_CHECK_EN for sticky rresp errors.
module amba_axi_read_burst #(
   parameter int          DATA_W     = 32,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [3:0]  AXI_ID     = 4'b0000
) (
   input  logic              aclk,
   input  logic              areset,
   // request side
   input  logic [31:0]       aacaddr,
   input  logic [3:0]        aaclen,
   input  logic              aacreq,
   output logic              aacack,
   // AR channel
   output logic [3:0]        arid,
   output logic [31:0]       araddr,
   output logic [3:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [1:0]        arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   // R channel
   input  logic [3:0]        rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   // data side
   output logic [DATA_W-1:0] aacdata,
   output logic              aacdatavalid,
   input  logic              aacdataready,
   output logic              aaclast,
   output logic              aacerr,
   output logic              busy
);

   localparam int          SIZE      = $clog2(DATA_W / 8);
   localparam int          PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [31:0] ADDR_MASK = ~32'(DATA_W / 8 - 1);
   localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state;
   logic [3:0]        len;
   logic [3:0]        beat_cnt;
   logic              beat_last;

   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [DATA_W:0]   head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              full;
   logic              push;
   logic              pop;
   logic              accept;

   // rid and rlast are deliberately not checked; the beat counter decides the last beat.
   logic              unused_inputs;
   assign unused_inputs = ^{rid, rlast, rresp};

   assign arid    = AXI_ID;
   assign arsize  = 3'(SIZE);
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0001;
   assign arprot  = 3'b010;
   assign arlen   = len;

   assign busy      = (state != IDLE);
   assign accept    = (state == IDLE) && aacreq;
   assign full      = (count == FULL_CNT);
   assign rready    = (state == DATA) && !full;
   assign push      = rvalid && rready;
   assign pop       = aacdatavalid && aacdataready;
   assign beat_last = (beat_cnt == len);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         arvalid  <= 1'b0;
         araddr   <= 32'h0;
         len      <= 4'h0;
         beat_cnt <= 4'h0;
         aacack   <= 1'b0;
      end else begin
         aacack <= 1'b0;
         case (state)
            IDLE: begin
               if (aacreq) begin
                  araddr   <= aacaddr & ADDR_MASK;
                  len      <= aaclen;
                  beat_cnt <= 4'h0;
                  arvalid  <= 1'b1;
                  aacack   <= 1'b1;
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (arvalid && arready) begin
                  arvalid <= 1'b0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (push) begin
                  if (beat_last) begin
                     beat_cnt <= 4'h0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is not reset; the outputs are gated by aacdatavalid instead.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wr_ptr] <= {rdata, beat_last};
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head         = mem[rd_ptr];
   assign aacdatavalid = (count != '0);
   assign aacdata      = aacdatavalid ? head[DATA_W:1] : '0;
   assign aaclast      = aacdatavalid ? head[0] : 1'b0;

`ifdef AMBA_AXI_READ_RESP_CHECK_EN
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         aacerr <= 1'b0;
      end else if (accept) begin
         aacerr <= 1'b0;
      end else if (push && rresp[1]) begin
         aacerr <= 1'b1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign aacerr        = 1'b0;
`endif

endmodule

// File: tb/tb_amba_axi_read_burst.sv
// Directed self-checking bench for amba_axi_read_burst (FIFO_DEPTH=4, DATA_W=32).
module tb_amba_axi_read_burst;

   localparam int DATA_W = 32;
`ifdef AMBA_AXI_READ_RESP_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic              clk;
   logic              areset;
   logic [31:0]       aacaddr;
   logic [3:0]        aaclen;
   logic              aacreq;
   logic              aacack;
   logic [3:0]        arid;
   logic [31:0]       araddr;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [1:0]        arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [3:0]        rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] aacdata;
   logic              aacdatavalid;
   logic              aacdataready;
   logic              aaclast;
   logic              aacerr;
   logic              busy;

   int checks;
   int errors;
   int ar_hs;
   logic [32:0] got_q[$];

   amba_axi_read_burst #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (4),
      .AXI_ID     (4'b0000)
   ) dut (
      .aclk         (clk),
      .areset       (areset),
      .aacaddr      (aacaddr),
      .aaclen       (aaclen),
      .aacreq       (aacreq),
      .aacack       (aacack),
      .arid         (arid),
      .araddr       (araddr),
      .arlen        (arlen),
      .arsize       (arsize),
      .arburst      (arburst),
      .arlock       (arlock),
      .arcache      (arcache),
      .arprot       (arprot),
      .arvalid      (arvalid),
      .arready      (arready),
      .rid          (rid),
      .rdata        (rdata),
      .rresp        (rresp),
      .rlast        (rlast),
      .rvalid       (rvalid),
      .rready       (rready),
      .aacdata      (aacdata),
      .aacdatavalid (aacdatavalid),
      .aacdataready (aacdataready),
      .aaclast      (aaclast),
      .aacerr       (aacerr),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at posedge+2, so the negedge sees the values the next posedge will use.
   always @(negedge clk) begin
      if (!areset && aacdatavalid && aacdataready) got_q.push_back({aaclast, aacdata});
      if (!areset && arvalid && arready) ar_hs++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic request(input logic [31:0] addr, input logic [3:0] len);
      aacaddr = addr;
      aaclen  = len;
      aacreq  = 1'b1;
      tick();
      aacreq  = 1'b0;
   endtask

   task automatic send_beats(input int first, input int num, input int len,
                             input logic [31:0] base, input int err_idx, input bit use_rlast);
      int waited;
      for (int i = first; i < first + num; i++) begin
         waited = 0;
         rvalid = 1'b1;
         rdata  = base + 32'(i);
         rresp  = (i == err_idx) ? 2'b10 : 2'b00;
         rlast  = use_rlast && (i == len);
         @(negedge clk);
         while (!rready && waited < 50) begin
            @(negedge clk);
            waited++;
         end
         if (!rready) check("r_timeout", 64'd0, 64'd1);
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
   endtask

   task automatic drain(input string tag, input int n);
      int waited;
      waited = 0;
      while (got_q.size() < n && waited < 60) begin
         tick();
         waited++;
      end
      tick();
      check(tag, 64'(got_q.size()), 64'(n));
   endtask

   task automatic check_beats(input string tag, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         if (i < got_q.size()) check(tag, 64'(got_q[i]), 64'({(i == n - 1), base + 32'(i)}));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ar_hs = 0;
      areset = 1'b1;
      aacaddr = '0;
      aaclen = '0;
      aacreq = 1'b0;
      arready = 1'b0;
      rid = 4'h0;
      rdata = '0;
      rresp = 2'b00;
      rlast = 1'b0;
      rvalid = 1'b0;
      aacdataready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_araddr", 64'(araddr), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);
      check("rst_aacack", 64'(aacack), 64'd0);
      check("rst_dvalid", 64'(aacdatavalid), 64'd0);
      check("rst_aacdata", 64'(aacdata), 64'd0);
      check("rst_aaclast", 64'(aaclast), 64'd0);
      check("rst_aacerr", 64'(aacerr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      areset = 1'b0;
      tick();

      // Basic 4-beat burst, arready already high.
      arready = 1'b1;
      aacdataready = 1'b1;
      ar_hs = 0;
      request(32'h0000_1000, 4'd3);
      check("t28_aacack", 64'(aacack), 64'd1);
      check("t28_arvalid", 64'(arvalid), 64'd1);
      check("t28_araddr", 64'(araddr), 64'h1000);
      check("t28_arlen", 64'(arlen), 64'd3);
      check("t28_arburst", 64'(arburst), 64'd1);
      check("t28_arsize", 64'(arsize), 64'd2);
      check("t28_arlock", 64'(arlock), 64'd0);
      check("t28_arcache", 64'(arcache), 64'd1);
      check("t28_arprot", 64'(arprot), 64'd2);
      check("t28_arid", 64'(arid), 64'd0);
      check("t28_busy", 64'(busy), 64'd1);
      check("t28_rready_addr", 64'(rready), 64'd0);
      tick();
      check("t28_aacack_pulse", 64'(aacack), 64'd0);
      check("t28_arvalid_drop", 64'(arvalid), 64'd0);
      check("t28_rready_data", 64'(rready), 64'd1);
      send_beats(0, 4, 3, 32'h0000_00A0, -1, 1'b1);
      drain("t28_count", 4);
      check_beats("t28_beat", 4, 32'h0000_00A0);
      check("t28_ar_hs", 64'(ar_hs), 64'd1);
      check("t28_idle", 64'(busy), 64'd0);

      // AR stall: unaligned address, requests ignored while busy.
      got_q.delete();
      arready = 1'b0;
      ar_hs = 0;
      request(32'h0000_2006, 4'd1);
      check("t29_araddr_align", 64'(araddr), 64'h2004);
      aacreq = 1'b1;
      aacaddr = 32'hFFFF_FFF0;
      aaclen = 4'hF;
      repeat (5) begin
         tick();
         check("t29_arvalid_hold", 64'(arvalid), 64'd1);
         check("t29_araddr_hold", 64'(araddr), 64'h2004);
         check("t29_arlen_hold", 64'(arlen), 64'd1);
         check("t29_no_ack", 64'(aacack), 64'd0);
         check("t29_rready_addr", 64'(rready), 64'd0);
      end
      aacreq = 1'b0;
      arready = 1'b1;
      tick();
      check("t29_arvalid_drop", 64'(arvalid), 64'd0);
      send_beats(0, 2, 1, 32'h0000_00B0, -1, 1'b1);
      drain("t29_count", 2);
      check_beats("t29_beat", 2, 32'h0000_00B0);
      check("t29_ar_hs", 64'(ar_hs), 64'd1);

      // Backpressure: 8 beats into a 4-entry buffer, rlast never driven.
      got_q.delete();
      aacdataready = 1'b0;
      request(32'h0000_3000, 4'd7);
      tick();
      send_beats(0, 4, 7, 32'h0000_00C0, -1, 1'b0);
      check("t30_rready_full", 64'(rready), 64'd0);
      check("t30_dvalid", 64'(aacdatavalid), 64'd1);
      check("t30_head", 64'(aacdata), 64'h00C0);
      repeat (3) tick();
      check("t30_rready_stall", 64'(rready), 64'd0);
      check("t30_none_out", 64'(got_q.size()), 64'd0);
      aacdataready = 1'b1;
      send_beats(4, 4, 7, 32'h0000_00C0, -1, 1'b0);
      drain("t30_count", 8);
      check_beats("t30_beat", 8, 32'h0000_00C0);

      // Error response on the second beat.
      got_q.delete();
      request(32'h0000_4000, 4'd3);
      tick();
      send_beats(0, 4, 3, 32'h0000_00D0, 1, 1'b1);
      drain("t31_count", 4);
      check("t31_aacerr", 64'(aacerr), 64'(EXP_ERR));
      repeat (2) tick();
      check("t31_aacerr_sticky", 64'(aacerr), 64'(EXP_ERR));

      // Reset during beat 2 of 8, then a clean burst.
      got_q.delete();
      request(32'h0000_5000, 4'd7);
      check("t32_aacerr_clear", 64'(aacerr), 64'd0);
      tick();
      send_beats(0, 1, 7, 32'h0000_00E0, -1, 1'b1);
      rvalid = 1'b1;
      rdata = 32'h0000_00E1;
      #1 areset = 1'b1;
      #1;
      check("t32_arvalid", 64'(arvalid), 64'd0);
      check("t32_araddr", 64'(araddr), 64'd0);
      check("t32_rready", 64'(rready), 64'd0);
      check("t32_aacack", 64'(aacack), 64'd0);
      check("t32_dvalid", 64'(aacdatavalid), 64'd0);
      check("t32_aacdata", 64'(aacdata), 64'd0);
      check("t32_aaclast", 64'(aaclast), 64'd0);
      check("t32_aacerr", 64'(aacerr), 64'd0);
      check("t32_busy", 64'(busy), 64'd0);
      rvalid = 1'b0;
      tick();
      areset = 1'b0;
      tick();
      got_q.delete();
      ar_hs = 0;
      request(32'h0000_6008, 4'd1);
      check("t32_re_araddr", 64'(araddr), 64'h6008);
      check("t32_re_arvalid", 64'(arvalid), 64'd1);
      tick();
      send_beats(0, 2, 1, 32'h0000_00F0, -1, 1'b1);
      drain("t32_count", 2);
      check_beats("t32_beat", 2, 32'h0000_00F0);
      check("t32_ar_hs", 64'(ar_hs), 64'd1);
      check("t32_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/amba_axi_read_burst.md
AMBA_AXI_READ_BURST -- requirements
Module: amba_axi_read_burst

Interface
REQ-001 SHALL provide parameter DATA_W, 32, AXI/AAC data width in bits (32 or 64).
REQ-002 SHALL provide parameter FIFO_DEPTH, 8, read-data buffer entries (power of two, 2..32).
REQ-003 SHALL provide parameter AXI_ID, 4'b0000, constant driven on arid.
REQ-004 SHALL use one clock; reset is asynchronous and active-high: aclk input 1, rising-edge clock; areset input 1, asynchronous active-high reset.
REQ-005 SHALL have ports: aacaddr in 32, burst start byte address; aaclen in 4, beats minus one; aacreq in 1, request valid; aacack out 1, request accepted (one-cycle pulse).
REQ-006 SHALL have AR ports: arid out 4; araddr out 32; arlen out 4; arsize out 3; arburst out 2; arlock out 2; arcache out 4; arprot out 3; arvalid out 1; arready in 1.
REQ-007 SHALL have R ports: rid in 4; rdata in DATA_W; rresp in 2; rlast in 1; rvalid in 1; rready out 1.
REQ-008 SHALL have AAC ports: aacdata out DATA_W; aacdatavalid out 1; aacdataready in 1; aaclast out 1, final beat of burst; aacerr out 1, sticky response error; busy out 1, not IDLE.

Function
REQ-009 SHALL implement states IDLE, ADDR, DATA; busy = (state != IDLE).
REQ-010 IDLE: aacreq=1 -> latch aacaddr/aaclen, pulse aacack, go ADDR; arvalid=1 from next cycle.
REQ-011 aacreq SHALL be ignored (aacack=0) in ADDR and DATA.
REQ-012 ADDR: araddr/arlen/arvalid stable until arready=1 sampled with arvalid=1; then arvalid=0, go DATA.
REQ-013 Constants: arburst=2'b01 (INCR), arsize=log2(DATA_W/8), arlock=2'b00, arcache=4'b0001, arprot=3'b010, arid=AXI_ID.
REQ-014 araddr SHALL be aacaddr with low log2(DATA_W/8) bits forced to zero.
REQ-015 rready SHALL be 1 in DATA when FIFO not full, else 0; rready=0 in IDLE and ADDR.
REQ-016 Each beat with rvalid&rready SHALL push {rdata, last} into FIFO; beat counter 4-bit, compared with latched len.
REQ-017 last flag SHALL be set when counter == len, regardless of rlast; rlast ignored otherwise.
REQ-018 On the final beat handshake, state SHALL go IDLE same edge; counter clears.
REQ-019 FIFO show-ahead: aacdatavalid=1 the cycle after push into empty FIFO; aacdata/aaclast show head entry.
REQ-020 Pop on aacdatavalid&aacdataready; simultaneous push and pop when full SHALL NOT occur (rready=0 when full); simultaneous push/pop otherwise keeps count unchanged.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-022 New request MAY be accepted while FIFO still drains; FIFO order preserved across bursts.
REQ-023 rid SHALL not be checked.

Reset
REQ-024 areset=1 SHALL asynchronously force IDLE, arvalid=0, araddr=0, rready=0, aacack=0, FIFO empty, aacdatavalid=0, aacdata=0, aaclast=0, aacerr=0, busy=0.
REQ-025 Reset mid-burst SHALL discard in-flight beats; first request after release restarts at ADDR.

Configuration
REQ-026 Macro AMBA_AXI_READ_RESP_CHECK_EN defined: any accepted beat with rresp[1]=1 (SLVERR/DECERR) SHALL set aacerr, cleared only by next aacack or reset.
REQ-027 Macro undefined: rresp ignored, aacerr tied 0.

Verification
REQ-028 aacaddr=0x1000, aaclen=3, arready same cycle -> araddr=0x1000, arlen=3, arburst=01, four beats out, aaclast on 4th only.
REQ-029 arready held 0 for 5 cycles -> arvalid and araddr stable throughout, single AR transfer.
REQ-030 FIFO_DEPTH=4, aaclen=7, aacdataready=0 -> rready falls after 4 beats; release -> all 8 beats in order, none lost.
REQ-031 beat 2 of 4 with rresp=2'b10, macro defined -> aacerr=1 until next aacack; macro undefined -> aacerr=0.
REQ-032 areset pulsed during beat 2 of 8 -> all outputs at reset values same cycle; next request completes normally.
